// File: rtl/mul_div_unit_pkg.sv
// Shared RV32M multiply/divide definitions, used by decode/control and by
// mul_div_unit: the default datapath width, the funct3 op codes and the
// MDU sequencer state encoding.
package mul_div_unit_pkg;

  localparam int unsigned MDU_XLEN = 32;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit (execute stage, beside the ALU).
// Fixed latency of XLEN+2 cycles from the accepting edge to the end of done.
//   clk, rst_n     : clock, synchronous active-low reset
//   start          : request, accepted only when the unit is free
//   funct3         : RV32M op select (MUL..REMU)
//   op_a, op_b     : rs1 / rs2 data (multiplicand/dividend, multiplier/divisor)
//   rd_in          : destination register index
//   busy           : unit occupied (core stalls on this)
//   done           : one-cycle pulse, result/rd_out valid, drives RF we
//   result, rd_out : registered result and destination index
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int unsigned CW = $clog2(XLEN);

  mdu_state_e        state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        f_q, f_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [2*XLEN-1:0] p_q, p_d;      // {acc/remainder, multiplier/quotient}
  logic [XLEN-1:0]   m_q, m_d;      // multiplicand or divisor magnitude
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_q, rd_d;

  logic              sign_a, sign_b, accept;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              is_div, neg;
  logic [XLEN+1:0]   as_x, as_y, as_r;
  logic [2*XLEN-1:0] p_step, prod;
  logic [XLEN-1:0]   quot, rem, fix_res;

  // Operand classification for the incoming request.
  always_comb begin
    sign_a = op_a[XLEN-1] &
             (funct3 inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM});
    sign_b = op_b[XLEN-1] & (funct3 inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM});
    mag_a  = sign_a ? -op_a : op_a;
    mag_b  = sign_b ? -op_b : op_b;
  end

  // One shared adder/subtractor. Multiply adds m to the accumulator with
  // carry out; divide subtracts m from {remainder, next dividend bit} and
  // uses the sign of the wide result as the restore decision.
  always_comb begin
    is_div = f_q[2];
    as_x   = is_div ? {1'b0, p_q[2*XLEN-1:XLEN-1]} : {2'b00, p_q[2*XLEN-1:XLEN]};
    as_y   = {2'b00, m_q} ^ {(XLEN+2){is_div}};
    as_r   = as_x + as_y + (XLEN+2)'(is_div);
    if (is_div) begin
      if (as_r[XLEN+1]) p_step = {p_q[2*XLEN-2:0], 1'b0};
      else              p_step = {as_r[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
    end else if (p_q[0]) begin
      p_step = {as_r[XLEN:0], p_q[XLEN-1:1]};
    end else begin
      p_step = {1'b0, p_q[2*XLEN-1:1]};
    end
  end

  // Sign correction and result select. Divide-by-zero on magnitudes already
  // leaves the dividend as remainder, and signed overflow falls out of the
  // magnitude arithmetic; only the zero-divisor quotient needs an override.
  always_comb begin
    neg  = sa_q ^ sb_q;
    prod = neg ? -p_q : p_q;
    quot = neg ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
    rem  = sa_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
    case (f_q)
      MDU_MUL:                        fix_res = prod[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:              fix_res = (m_q == '0) ? '1 : quot;
      default:                        fix_res = rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    f_d      = f_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    p_d      = p_q;
    m_d      = m_q;
    result_d = result_q;
    rd_d     = rd_q;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: accept = start;
      CALC: begin
        p_d     = p_step;
        count_d = count_q + CW'(1);
        if (count_q == CW'(XLEN-1)) state_d = FIX;
      end
      FIX: begin
        result_d = fix_res;
        rd_d     = rd_q;
        state_d  = DONE;
      end
      // DONE doubles as an accept slot so back-to-back ops issue every XLEN+2 cycles.
      DONE: begin
        state_d = IDLE;
        accept  = start;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = CALC;
      count_d = '0;
      f_d     = funct3;
      sa_d    = sign_a;
      sb_d    = sign_b;
      p_d     = funct3[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
      m_d     = funct3[2] ? mag_b : mag_a;
    end
  end

  // rd_out only becomes visible at the FIX->DONE edge; the latched index
  // lives in rd_lat_q until then.
  logic [4:0] rd_lat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      f_q      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      p_q      <= '0;
      m_q      <= '0;
      result_q <= '0;
      rd_q     <= '0;
      rd_lat_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      f_q      <= f_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      p_q      <= p_d;
      m_q      <= m_d;
      result_q <= result_d;
      if (accept) rd_lat_q <= rd_in;
      if (state_q == FIX) rd_q <= rd_lat_q;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_vec = 0;
  int n_err = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operand values.
  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    bit a_s, b_s;
    a_s = f inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    b_s = f inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
    sa = a_s ? longint'($signed(a)) : longint'(a);
    sb = b_s ? longint'($signed(b)) : longint'(b);
    if (f == MDU_MUL) begin
      p = sa * sb;
      return p[31:0];
    end
    if (f inside {MDU_MULH, MDU_MULHSU, MDU_MULHU}) begin
      p = sa * sb;
      return p[63:32];
    end
    if (b == 32'd0) return (f inside {MDU_DIV, MDU_DIVU}) ? 32'hFFFFFFFF : a;
    q = sa / sb;
    r = sa % sb;
    p = (f inside {MDU_DIV, MDU_DIVU}) ? q : r;
    return p[31:0];
  endfunction

  // Launch one op and follow it for XLEN+3 cycles; cycle k is the interval
  // after edge Ek, with E0 the accepting edge.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int          ndone = 0;
    int          done_cyc = -1;
    logic [31:0] res = '0;
    logic [4:0]  rdo = '0;
    logic        busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    @(posedge clk);
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
        rd_in = 5'($urandom);
      end
      if (busy !== (k <= 33)) busy_ok = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        done_cyc = k;
        res = result;
        rdo = rd_out;
      end
    end
    check({name, ".result"}, res, exp);
    check({name, ".rd_out"}, 32'(rdo), 32'(rd));
    check({name, ".done_cycle"}, 32'(done_cyc), 32'd33);
    check({name, ".busy_window"}, 32'(busy_ok), 32'd1);
    if (ndone != 1) check({name, ".done_count"}, 32'(ndone), 32'd1);
  endtask

  initial begin
    vec_t tbl[$];
    rst_n = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;

    tbl.push_back('{MDU_MUL,    32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB});
    tbl.push_back('{MDU_MULH,   32'h80000000,   32'h80000000, 5'd6,  32'h40000000});
    tbl.push_back('{MDU_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE});
    tbl.push_back('{MDU_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF});
    tbl.push_back('{MDU_DIV,    32'hFFFFFFF9,   32'd2,        5'd9,  32'hFFFFFFFD});
    tbl.push_back('{MDU_REM,    32'hFFFFFFF9,   32'd2,        5'd10, 32'hFFFFFFFF});
    tbl.push_back('{MDU_DIVU,   32'd100,        32'd7,        5'd11, 32'd14});
    tbl.push_back('{MDU_REMU,   32'd100,        32'd7,        5'd12, 32'd2});
    tbl.push_back('{MDU_DIV,    32'd5,          32'd0,        5'd13, 32'hFFFFFFFF});
    tbl.push_back('{MDU_REM,    32'd5,          32'd0,        5'd14, 32'd5});
    tbl.push_back('{MDU_DIV,    32'h80000000,   32'hFFFFFFFF, 5'd15, 32'h80000000});
    tbl.push_back('{MDU_REM,    32'h80000000,   32'hFFFFFFFF, 5'd16, 32'd0});
    tbl.push_back('{MDU_DIV,    32'hFFFFFFFB,   32'd0,        5'd17, 32'hFFFFFFFF});
    tbl.push_back('{MDU_REM,    32'd7,          32'hFFFFFFFE, 5'd18, 32'd1});
    tbl.push_back('{MDU_DIV,    32'd7,          32'hFFFFFFFE, 5'd19, 32'hFFFFFFFD});
    tbl.push_back('{MDU_DIVU,   32'hFFFFFFFF,   32'd1,        5'd31, 32'hFFFFFFFF});
    tbl.push_back('{MDU_MUL,    32'h12345678,   32'd0,        5'd1,  32'd0});

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.busy",   32'(busy),   32'd0);
    check("reset.done",   32'(done),   32'd0);
    check("reset.result", result,      32'd0);
    check("reset.rd_out", 32'(rd_out), 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      logic [4:0]  rd;
      f  = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      rd = 5'($urandom);
      run_op($sformatf("rand%0d", i), f, a, b, rd, ref_mdu(f, a, b));
    end

    // start held high; operands change mid-op and become the second request.
    begin
      int          ndone = 0;
      int          cyc[2] = '{-1, -1};
      logic [31:0] res[2] = '{32'd0, 32'd0};
      logic [4:0]  rdo[2] = '{5'd0, 5'd0};
      @(negedge clk);
      start = 1'b1; funct3 = MDU_MUL; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd1;
      @(posedge clk);
      for (int k = 0; k <= 75; k++) begin
        @(negedge clk);
        if (k == 5) begin
          funct3 = MDU_DIVU; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd2;
        end
        if (k == 40) begin
          op_a = 32'd999; op_b = 32'd3; funct3 = MDU_MUL;
        end
        if (k == 66) start = 1'b0;
        if (done === 1'b1) begin
          if (ndone < 2) begin
            cyc[ndone] = k; res[ndone] = result; rdo[ndone] = rd_out;
          end
          ndone++;
        end
      end
      check("held.done_count", 32'(ndone),  32'd2);
      check("held.cyc0",       32'(cyc[0]), 32'd33);
      check("held.res0",       res[0],      32'd12);
      check("held.rd0",        32'(rdo[0]), 32'd1);
      check("held.cyc1",       32'(cyc[1]), 32'd67);
      check("held.res1",       res[1],      32'd14);
      check("held.rd1",        32'(rdo[1]), 32'd2);
    end

    // Reset at cycle 10 of a DIV aborts it.
    begin
      int ndone = 0;
      @(negedge clk);
      start = 1'b1; funct3 = MDU_DIV; op_a = 32'hFFFFFF9C; op_b = 32'd7; rd_in = 5'd9;
      @(posedge clk);
      for (int k = 0; k <= 10; k++) begin
        @(negedge clk);
        if (k == 0) start = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("abort.busy",   32'(busy),   32'd0);
      check("abort.done",   32'(done),   32'd0);
      check("abort.result", result,      32'd0);
      check("abort.rd_out", 32'(rd_out), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done === 1'b1) ndone++;
      end
      check("abort.no_done", 32'(ndone), 32'd0);
      run_op("after_abort", MDU_REM, 32'hFFFFFF9C, 32'd7, 5'd9, 32'hFFFFFFFE);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
